sprite_line_fetch: RTL

Downstream consumer of the VGA sprite RAM's 16-bit read port (2048 × 16-bit words, RGB565, two 32×32 animation frames). On each line-start pulse during horizontal blanking, it decides whether the next scan line intersects the sprite. On a hit it burst-reads that sprite row into a 32-entry line buffer. During the active region it delivers registered pixel colour with transparency keying to the VGA colour mixer.

---
 rtl/sprite_line_fetch.sv | 178 +++++++++++++++++
 1 files changed

// File: rtl/sprite_line_fetch.sv
// sprite_line_fetch
//   Reads one sprite row from the sprite RAM read port into a line buffer
//   during horizontal blanking. During the active region it produces
//   registered, transparency-keyed sprite pixels for the colour mixer.
//
//   Ports
//     clk            pixel/system clock (shared with RAM port 2)
//     reset_n        asynchronous active-low reset
//     line_start     1-cycle pulse at hblank start, precedes line next_y
//     next_y         line about to be displayed          (sampled on line_start)
//     draw_x         current pixel column in the active region
//     sprite_x/_y    sprite top-left corner              (sampled on line_start)
//     frame_sel      animation frame                     (sampled on line_start)
//     sprite_en      sprite visible                      (sampled on line_start)
//     mirror_x       horizontal mirror, only with SPRITE_MIRROR_EN defined
//     ram_address    RAM word address (registered)
//     ram_chipselect RAM chipselect (registered)
//     ram_readdata   RAM data, valid 1 cycle after the address
//     pixel_valid    pixel_rgb is to be drawn
//     pixel_rgb      sprite colour for draw_x of the previous cycle
//     busy           fetch in progress
//
//   Build option: define SPRITE_MIRROR_EN to add the mirror_x input.
module sprite_line_fetch #(
   parameter int          SPRITE_W    = 32,
   parameter int          SPRITE_H    = 32,
   parameter int          FRAME_WORDS = 1024,
   parameter logic [15:0] TRANSPARENT = 16'hF81F
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        line_start,
   input  logic [9:0]  next_y,
   input  logic [9:0]  draw_x,
   input  logic [9:0]  sprite_x,
   input  logic [9:0]  sprite_y,
   input  logic        frame_sel,
   input  logic        sprite_en,
`ifdef SPRITE_MIRROR_EN
   input  logic        mirror_x,
`endif
   output logic [10:0] ram_address,
   output logic        ram_chipselect,
   input  logic [15:0] ram_readdata,
   output logic        pixel_valid,
   output logic [15:0] pixel_rgb,
   output logic        busy
);

   localparam int IW = (SPRITE_W > 1) ? $clog2(SPRITE_W) : 1;

   typedef enum logic [1:0] {IDLE, FETCH, DRAIN, READY} state_t;

   state_t        state, state_nx;
   logic [IW-1:0] i, i_nx, i_d;
   logic          cap_en, cap_nx;
   logic          line_hit, line_hit_nx;
   logic [9:0]    x_lat;
   logic [10:0]   addr_nx;
   logic          cs_nx;
   logic [10:0]   row, base;
   logic          hit;
   logic [10:0]   col;
   logic          in_win;
   logic [IW-1:0] idx;
   logic [15:0]   rd;
   logic [15:0]   buffer [SPRITE_W];

`ifdef SPRITE_MIRROR_EN
   logic          mirror_lat;
`endif

   // Line evaluation and fetch sequencing
   always_comb begin
      row  = {1'b0, next_y} - {1'b0, sprite_y};
      hit  = sprite_en && !row[10] && (row < 11'(SPRITE_H));
      base = (frame_sel ? 11'(FRAME_WORDS) : '0) + row * 11'(SPRITE_W);

      state_nx    = state;
      i_nx        = i;
      line_hit_nx = line_hit;
      addr_nx     = ram_address;
      cs_nx       = ram_chipselect;
      cap_nx      = 1'b0;

      // line_start wins in every state, which also aborts a fetch in flight
      if (line_start) begin
         line_hit_nx = 1'b0;
         i_nx        = '0;
         if (hit) begin
            state_nx = FETCH;
            addr_nx  = base;
            cs_nx    = 1'b1;
         end else begin
            state_nx = IDLE;
            cs_nx    = 1'b0;
         end
      end else begin
         case (state)
            FETCH: begin
               // data for address i arrives next cycle, stored at i_d
               cap_nx = 1'b1;
               if (i == IW'(SPRITE_W - 1)) begin
                  state_nx = DRAIN;
                  cs_nx    = 1'b0;
               end else begin
                  i_nx    = i + 1'b1;
                  addr_nx = ram_address + 11'd1;
               end
            end
            DRAIN: begin
               state_nx    = READY;
               line_hit_nx = 1'b1;
            end
            default: ;
         endcase
      end

      busy = (state == FETCH) || (state == DRAIN);
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state          <= IDLE;
         i              <= '0;
         i_d            <= '0;
         cap_en         <= 1'b0;
         line_hit       <= 1'b0;
         x_lat          <= '0;
         ram_address    <= '0;
         ram_chipselect <= 1'b0;
      end else begin
         state          <= state_nx;
         i              <= i_nx;
         i_d            <= i;
         cap_en         <= cap_nx;
         line_hit       <= line_hit_nx;
         ram_address    <= addr_nx;
         ram_chipselect <= cs_nx;
         if (line_start) x_lat <= sprite_x;
      end
   end

`ifdef SPRITE_MIRROR_EN
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)        mirror_lat <= 1'b0;
      else if (line_start) mirror_lat <= mirror_x;
   end
`endif

   // Line buffer: no reset, contents only meaningful once READY
   always_ff @(posedge clk) begin
      if (cap_en) buffer[i_d] <= ram_readdata;
   end

   // Pixel path
   always_comb begin
      col    = {1'b0, draw_x} - {1'b0, x_lat};
      in_win = line_hit && !col[10] && (col < 11'(SPRITE_W));
`ifdef SPRITE_MIRROR_EN
      idx    = mirror_lat ? (IW'(SPRITE_W - 1) - col[IW-1:0]) : col[IW-1:0];
`else
      idx    = col[IW-1:0];
`endif
      rd     = buffer[idx];
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         pixel_valid <= 1'b0;
         pixel_rgb   <= '0;
      end else begin
         pixel_valid <= in_win && (rd != TRANSPARENT);
         pixel_rgb   <= in_win ? rd : '0;
      end
   end

endmodule
